seg_scan_controller: RTL
========================

Name: seg_scan_controller

Overview:
Sequencer for the 4-digit multiplexed seven-segment datapath. It time-slices one shared sevensegment decoder across four digits. Each digit gets three phases: SELECT, SHOW and BLANK.
- Data is accepted through a valid/ready load port and committed atomically at frame boundaries, so a digit never tears mid-frame.
- Leading-zero blanking and per-digit enables are optional.
- Sits between the data source and the sevensegment decoder / digit anode drivers, in the display clock domain.

Parameters:
TICK_DIV, 16, clock cycles per phase (legal values ≥2; the sim bench uses 4)
DIGITS, 4, number of digits scanned (fixed at 4 for this revision; the select encoding assumes 4)

Ports:
clk  input  1  display clock (single clock domain)
rst  input  1  synchronous, active-high reset
data_in  input  16  four BCD/hex nibbles; digit0 = [3:0], digit3 = [15:12]
load_valid  input  1  data_in valid
load_ready  output  1  pending slot free; transfer on load_valid & load_ready
blank_lz  input  1  enable leading-zero blanking (sampled every SHOW phase)
digit_en  input  4  per-digit enable, bit i = digit i (sampled every SHOW phase)
select  output  4  active-low digit select; d0=0111, d1=1011, d2=1101, d3=1110, off=1111
nibble_out  output  5  to sevensegment Data_in; bit4=1 means blank (10000), else {0,nibble}
frame_done  output  1  one-cycle pulse per completed frame

Behaviour:
- Reset (synchronous, rst=1 at posedge), all registered:
  - select=1111, nibble_out=10000, frame_done=0
  - active register=0000, pending empty, so load_ready=1
  - FSM at (digit0, SEL), phase counter=0
- Phase counter: 0..TICK_DIV-1. The phase advances on the edge where count==TICK_DIV-1.
- Phase order per digit is SEL→SHOW→BLANK. After BLANK the FSM moves to SEL of digit+1; digit3 BLANK wraps to digit0 SEL.
- Frame length = 12*TICK_DIV cycles.
- Outputs are registered and reflect the current (digit, phase) from the edge after that phase is entered, i.e. one cycle of latency.
  - SEL: select = code for the digit; nibble_out=10000.
  - SHOW: select held; nibble_out = {0, active nibble}, or 10000 if the digit is suppressed.
  - BLANK: select held; nibble_out=10000.
- Suppressed digit:
  - Any digit with digit_en[i]=0 is suppressed, and its select stays 1111 for all three of its phases. The slot still consumes time so brightness stays constant.
  - With blank_lz=1, digit i>0 is also suppressed if its nibble and all higher nibbles are 0.
  - Digit0 is never LZ-blanked; with active=0000 it shows 0.
- Load handshake:
  - load_ready = ~pending_full (combinational from the register).
  - On a transfer, pending ← data_in and pending_full ← 1.
- Commit:
  - On the final edge of digit3 BLANK, if pending_full: active ← pending and pending_full ← 0.
  - frame_done is high for the following cycle, whether or not a commit occurred.
- Simultaneous events:
  - A transfer cannot coincide with a commit of an already-full slot (ready is low).
  - A transfer on the frame-end edge with the slot empty lands in pending and commits at the next frame end.
  - Holding load_valid=1 with ready=0 leaves the data stalled and unchanged, with no loss.
- Reset mid-frame or mid-handshake: the next edge restores reset values; pending data is discarded.
- Changing digit_en or blank_lz mid-frame takes effect at the next SHOW phase.

Decomposition:
- Package seg_scan_pkg holds:
  - phase enum SEL/SHOW/BLANK
  - BLANK_CODE=5'b10000
  - SEL_OFF=4'b1111
  - select code table indexed by digit
- One sub-module, seg_scan_prescaler: TICK_DIV counter with sync rst, emits a phase_tick pulse.
- The FSM, handshake and LZ logic stay in the top module.

Test Plan (TICK_DIV=4, frame=48 cycles):
1. Reset, then load 16'hB7A5 (accepted in cycle 1) → frame 1 shows 0 on d0 and d1–d3 blank (LZ off: d1–d3 show 0); frame 2 d0..d3 SHOW nibble_out = 05,0A,07,0B; select sequence 0111,1011,1101,1110; frame_done every 48 cycles.
2. Back-to-back loads 16'h1234 then 16'h5678 with load_valid held → first accepted, ready low until frame end, second accepted the cycle after commit; displayed order 1234, then 5678 one frame later, with no tearing within any frame.
3. blank_lz=1, data 16'h0040 → d3 and d2 suppressed (select 1111, nibble 10000), d1=04, d0=00; data 16'h0000 → only d0 shows 00.
4. digit_en=4'b1010 → d0 and d2 slots keep select=1111 and nibble 10000 for 12 cycles each; frame length is still 48.
5. Assert rst mid-SHOW of d2 with pending full → next edge select=1111, nibble=10000, load_ready=1; after release the scan restarts at d0 SEL showing 0000.
6. load_valid pulsed on the exact frame-end edge with pending empty → data not visible in the next frame, visible in the one after; frame_done pulse width exactly 1 cycle.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan sequencer.
package seg_scan_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OUT_W  = 5;

  // Per-digit phase: drive the anode, show the nibble, then a dark guard slot.
  typedef enum logic [1:0] {
    PH_SEL   = 2'd0,
    PH_SHOW  = 2'd1,
    PH_BLANK = 2'd2
  } phase_e;

  localparam logic [OUT_W-1:0] BLANK_CODE = 5'b10000;
  localparam logic [SEL_W-1:0] SEL_OFF    = 4'b1111;

  // Active-low anode code indexed by digit number.
  localparam logic [3:0][SEL_W-1:0] SEL_CODE = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/seg_scan_prescaler.sv
// Phase-length divider: phase_tick is high on the last cycle of every phase.
module seg_scan_prescaler #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic phase_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count;

  // Count 0..TICK_DIV-1; the tick register mirrors count == TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      phase_tick <= 1'b0;
    end else if (count == CNT_W'(TICK_DIV - 1)) begin
      count      <= '0;
      phase_tick <= 1'b0;
    end else begin
      count      <= count + CNT_W'(1);
      phase_tick <= (count == CNT_W'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-slices one seven-segment decoder across four digits with frame-atomic data commit.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NIB_W*DIGITS-1:0]   data_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      blank_lz,
  input  logic [DIGITS-1:0]         digit_en,
  output logic [SEL_W-1:0]          select,
  output logic [OUT_W-1:0]          nibble_out,
  output logic                      frame_done
);

  localparam int unsigned DATA_W = NIB_W * DIGITS;

  logic              phase_tick;
  logic [1:0]        digit;
  phase_e            phase;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] pending;
  logic              pending_full;

  logic [NIB_W-1:0]  cur_nib_c;
  logic              suppress_c;
  logic              frame_end_c;

  seg_scan_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .phase_tick (phase_tick)
  );

  assign load_ready = ~pending_full;

  // Current digit's nibble and whether its slot is dark (disabled or leading zero).
  always_comb begin
    cur_nib_c   = active[{digit, 2'b00} +: NIB_W];
    suppress_c  = ~digit_en[digit];
    if (blank_lz && (digit != 2'd0) && ((active >> {digit, 2'b00}) == '0)) begin
      suppress_c = 1'b1;
    end
    frame_end_c = phase_tick && (digit == 2'd3) && (phase == PH_BLANK);
  end

  // Scan FSM and registered decoder/anode outputs, one cycle behind the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit      <= 2'd0;
      phase      <= PH_SEL;
      select     <= SEL_OFF;
      nibble_out <= BLANK_CODE;
      frame_done <= 1'b0;
    end else begin
      if (phase_tick) begin
        case (phase)
          PH_SEL:   phase <= PH_SHOW;
          PH_SHOW:  phase <= PH_BLANK;
          PH_BLANK: begin
            phase <= PH_SEL;
            digit <= digit + 2'd1;
          end
          default:  phase <= PH_SEL;
        endcase
      end
      select     <= suppress_c ? SEL_OFF : SEL_CODE[digit];
      nibble_out <= ((phase == PH_SHOW) && !suppress_c) ? {1'b0, cur_nib_c} : BLANK_CODE;
      frame_done <= frame_end_c;
    end
  end

  // Single-entry load slot; contents move to the display only at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (frame_end_c && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (load_valid && !pending_full) begin
      pending      <= data_in;
      pending_full <= 1'b1;
    end
  end

endmodule
